// File: rtl/shared_bus_arb_pkg.sv
// Shared types and helpers for the shared-bus owner scheduler.
package shared_bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, TURN} arb_state_t;

    // Index width with a floor of one bit so N=1 still yields a usable vector.
    function automatic int idw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req at index >= ptr, wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [IDW:0] sum;

    // Scan from farthest to nearest so the nearest hit at/after ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
            if (req[sum[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = sum[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner scheduler for a shared tristate bus: SETUP -> DRIVE -> TURN windows.
// Optional contention checker enabled by defining SHARED_BUS_ARB_CONTENTION_CHK_EN.
module shared_bus_arbiter
    import shared_bus_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1,
    parameter int IDW      = idw_of(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [N-1:0]   drv_seen,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   drv_en,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           err
);

    localparam int HW = idw_of(MAX_HOLD);
    localparam int TW = idw_of(TURN_CYC);
    localparam logic [HW-1:0]  HOLD_LIM = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0]  TURN_LIM = TW'(TURN_CYC - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

    arb_state_t     state, state_nx;
    logic [N-1:0]   gnt_nx, drv_nx, pick_oh;
    logic [IDW-1:0] id_nx, ptr, ptr_nx, ptr_inc, pick_idx;
    logic [HW-1:0]  hold_cnt, hold_nx;
    logic [TW-1:0]  turn_cnt, turn_nx;
    logic           pick_vld, own_req, own_last;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    assign own_req  = req[gnt_id];
    assign own_last = last[gnt_id];
    assign ptr_inc  = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        drv_nx   = drv_en;
        id_nx    = gnt_id;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        turn_nx  = turn_cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nx = SETUP;
                    gnt_nx   = pick_oh;
                    id_nx    = pick_idx;
                end
            end
            SETUP: begin
                if (own_req) begin
                    state_nx = DRIVE;
                    drv_nx   = gnt;
                    hold_nx  = '0;
                end else begin
                    // Owner withdrew before driving; skip TURN since the net stayed floated.
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    ptr_nx   = ptr_inc;
                end
            end
            DRIVE: begin
                hold_nx = hold_cnt + HW'(1);
                if (own_last || !own_req || hold_cnt == HOLD_LIM) begin
                    state_nx = TURN;
                    gnt_nx   = '0;
                    drv_nx   = '0;
                    ptr_nx   = ptr_inc;
                    turn_nx  = '0;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LIM) begin
                    if (pick_vld) begin
                        state_nx = SETUP;
                        gnt_nx   = pick_oh;
                        id_nx    = pick_idx;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    turn_nx = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                drv_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            drv_en   <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            drv_en   <= drv_nx;
            gnt_id   <= id_nx;
            busy     <= (state_nx != IDLE);
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            turn_cnt <= turn_nx;
        end
    end

`ifdef SHARED_BUS_ARB_CONTENTION_CHK_EN
    // Two drivers at once, or anyone driving without permission, latches err until reset.
    logic clash;
    assign clash = ($countones(drv_seen) > 1) || ((drv_seen & ~drv_en) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err <= 1'b0;
        else if (clash) err <= 1'b1;
    end
`else
    logic unused_drv_seen;
    assign unused_drv_seen = ^drv_seen;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Scoreboard bench: expected drive windows queued at stimulus, compared when each window closes.
module tb_shared_bus_arbiter;

    logic       clk, rst;
    logic [3:0] req, last, drv_seen, gnt, drv_en;
    logic [1:0] gnt_id;
    logic       busy, err;

`ifdef SHARED_BUS_ARB_CONTENTION_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    shared_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYC(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .drv_seen (drv_seen),
        .gnt      (gnt),
        .drv_en   (drv_en),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int id; int len;} win_t;
    win_t       exp_q[$];
    int         checks = 0, errors = 0;
    int         win_len = 0;
    logic [3:0] win_oh = '0;
    bit         win_bad = 0;

    // Advance to the next falling edge; check invariants and track drive windows.
    task automatic tick();
        win_t e;
        @(negedge clk);
        checks++;
        if ($countones(gnt) > 1 || $countones(drv_en) > 1 || (drv_en & ~gnt) != 4'b0) begin
            errors++;
            $display("FAIL invariant: gnt=%b drv_en=%b (want onehot0, drv_en within gnt)", gnt, drv_en);
        end
        if (drv_en != 4'b0) begin
            if (win_len == 0) begin win_oh = drv_en; win_bad = 0; end
            else if (drv_en != win_oh) win_bad = 1;
            win_len++;
        end else if (win_len > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL window_unexpected: got drv_en=%b for %0d cycles, want none", win_oh, win_len);
            end else begin
                e = exp_q.pop_front();
                if (win_bad || win_oh !== 4'(1 << e.id) || win_len != e.len) begin
                    errors++;
                    $display("FAIL window: got owner_oh=%b len=%0d changed=%0d, want owner %0d len %0d",
                             win_oh, win_len, win_bad, e.id, e.len);
                end
            end
            win_len = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; last = '0; drv_seen = '0;
        tick(); tick();
        checks++; if (gnt !== 4'b0)    begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (drv_en !== 4'b0) begin errors++; $display("FAIL reset_drv_en: got %b want 0000", drv_en); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0010; exp_q.push_back('{1, 1});
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b want 0010", gnt); end
        checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL single_gnt_id: got %0d want 1", gnt_id); end
        checks++; if (drv_en !== 4'b0) begin errors++; $display("FAIL single_setup_drv: got %b want 0000", drv_en); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        checks++; if (drv_en !== 4'b0010) begin errors++; $display("FAIL single_drv_en: got %b want 0010", drv_en); end
        req = 4'b0;
        tick();
        checks++; if (gnt !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_turn: got gnt=%b busy=%b want 0000/1", gnt, busy); end
        tick();
        checks++; if (busy !== 1'b0 || gnt_id !== 2'd1) begin errors++; $display("FAIL single_idle: got busy=%b id=%0d want 0/1", busy, gnt_id); end
    endtask

    task automatic test_last_handoff();
        req = 4'b0011; exp_q.push_back('{0, 3}); exp_q.push_back('{1, 1});
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL handoff_gnt0: got %b want 0001", gnt); end
        tick(); tick(); tick();
        last = 4'b0001;
        tick();
        last = 4'b0;
        checks++; if (gnt !== 4'b0 || drv_en !== 4'b0) begin errors++; $display("FAIL handoff_turn: got gnt=%b drv=%b want 0000", gnt, drv_en); end
        tick();
        checks++; if (gnt !== 4'b0010 || gnt_id !== 2'd1 || drv_en !== 4'b0) begin
            errors++; $display("FAIL handoff_gnt1: got gnt=%b id=%0d drv=%b want 0010/1/0000", gnt, gnt_id, drv_en); end
        tick();
        req = 4'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL handoff_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_hold_limit();
        req = 4'b0101;
        exp_q.push_back('{2, 8}); exp_q.push_back('{0, 8}); exp_q.push_back('{2, 1});
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL hold_gnt2: got %b want 0100", gnt); end
        repeat (9) tick();
        checks++; if (gnt !== 4'b0 || drv_en !== 4'b0) begin errors++; $display("FAIL hold_preempt: got gnt=%b drv=%b want 0000", gnt, drv_en); end
        tick();
        checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin errors++; $display("FAIL hold_gnt0: got gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
        repeat (10) tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL hold_return2: got %b want 0100", gnt); end
        tick();
        req = 4'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_setup_drop();
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_gnt3: got %b want 1000", gnt); end
        req = 4'b0;
        tick();
        checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        req = 4'b1001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_ptr0: got %b want 0001", gnt); end
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL drop_idle2: got %b want 0000", gnt); end
        exp_q.push_back('{3, 2});
        tick();
        checks++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin errors++; $display("FAIL drop_regrant: got gnt=%b id=%0d want 1000/3", gnt, gnt_id); end
        tick(); tick();
        last = 4'b1000;
        tick();
        last = 4'b0; req = 4'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_done: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        req = 4'b1111; exp_q.push_back('{0, 2});
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0 || drv_en !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got gnt=%b drv=%b busy=%b want 0000/0000/0", gnt, drv_en, busy); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin errors++; $display("FAIL rst_regrant: got gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
        req = 4'b0;
        tick();
    endtask

    task automatic test_contention();
        req = 4'b0010; exp_q.push_back('{1, 3});
        tick(); tick();
        checks++; if (drv_en !== 4'b0010) begin errors++; $display("FAIL chk_drv: got %b want 0010", drv_en); end
        drv_seen = 4'b0010;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_clean: got err=%b want 0", err); end
        drv_seen = 4'b0110;
        tick();
        checks++; if (err !== CHK) begin errors++; $display("FAIL chk_set: got err=%b want %b", err, CHK); end
        drv_seen = 4'b0; req = 4'b0;
        tick(); tick();
        checks++; if (err !== CHK) begin errors++; $display("FAIL chk_sticky: got err=%b want %b", err, CHK); end
        rst = 1'b1;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_rst: got err=%b want 0", err); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_last_handoff();
        test_hold_limit();
        test_setup_drop();
        test_reset_mid();
        test_contention();
        checks++;
        if (exp_q.size() != 0 || win_len != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending, open window %0d, want 0/0", exp_q.size(), win_len);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Round-robin owner scheduler for a shared, multi-driven (triand/tri) bus net.
- N requesters drive the bus through tristate or gate drivers. This block lets only one owner drive at a time.
- It inserts a setup cycle before each drive window and turnaround cycles after it, so two drivers never overlap on the net.
- It sits beside the bus net and feeds per-requester drive enables.

Parameters:
- N, 4, number of requesters (≥1)
- MAX_HOLD, 8, maximum drive cycles per grant before forced release (≥1)
- TURN_CYC, 1, bus-float cycles between owners (≥1)
- IDW, $clog2(N) (min 1), width of the grant index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester bus request, level
- last  in  N  owner marks final drive beat (sampled only for current owner in DRIVE)
- gnt  out  N  one-hot grant, high in SETUP and DRIVE
- drv_en  out  N  one-hot drive permission, high in DRIVE only
- gnt_id  out  IDW  index of current/last owner
- busy  out  1  state != IDLE
- err  out  1  sticky contention flag (SHARED_BUS_ARB_CONTENTION_CHK_EN only, else tied 0)
- drv_seen  in  N  driver-side "I am driving" report (used only with SHARED_BUS_ARB_CONTENTION_CHK_EN)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gnt=0, drv_en=0, gnt_id=0, busy=0, err=0
  - rr pointer ptr=0; hold_cnt=0; turn_cnt=0
  - Reset mid-window drops gnt/drv_en in the same cycle; no TURN is performed.
- States: IDLE, SETUP, DRIVE, TURN. All outputs are registered.
- Arbitration:
  - Winner = first set req bit at index ≥ ptr, wrapping modulo N.
  - Arbitration runs in IDLE, and at the end of TURN.
- IDLE:
  - Any req → SETUP next cycle; gnt[w]=1, gnt_id=w.
  - req→gnt latency is 1 cycle.
- SETUP (1 cycle):
  - Owner still requesting → DRIVE; drv_en[w]=1; hold_cnt=0.
  - Owner dropped req → IDLE; ptr=w+1; the bus was never driven.
- DRIVE:
  - hold_cnt increments each cycle.
  - Exit to TURN when the first of these occurs:
    - last[w]=1 (this beat is driven, then release)
    - req[w]=0 (release that cycle, drv_en low next edge)
    - hold_cnt==MAX_HOLD-1 (forced preemption)
  - On exit: gnt=0, drv_en=0, ptr=(w+1) mod N.
  - req on other requesters has no effect on the window.
- TURN:
  - All enables stay low for exactly TURN_CYC cycles (turn_cnt).
  - Then: any req → SETUP with the new winner directly (no IDLE cycle); otherwise → IDLE.
- Fairness:
  - Preempted owner keeping req set is re-granted only after all other pending requesters.
  - With N=1, it is re-granted after TURN.
- Simultaneous last and hold limit in the same cycle: a single TURN entry, identical result.
- Invariants: popcount(gnt)≤1, popcount(drv_en)≤1, drv_en ⊆ gnt.
- gnt_id holds its value through TURN and IDLE.

Optional Feature:
- SHARED_BUS_ARB_CONTENTION_CHK_EN defined:
  - Registered check each cycle.
  - err sets and stays set until rst if popcount(drv_seen)>1, or drv_seen & ~drv_en ≠ 0.
- Undefined: drv_seen is ignored; err is constant 0; no check logic is built.

Decomposition:
- Package shared_bus_arb_pkg holds:
  - state enum arb_state_t {IDLE, SETUP, DRIVE, TURN}
  - function for IDW (clog2 with min 1)
- Sub-module rr_pick: combinational; inputs req[N], ptr[IDW]; outputs valid, idx[IDW].
- FSM, counters and outputs live in shared_bus_arbiter.

Test Plan:
- N=4; req=0010 from idle → gnt=0010 and gnt_id=1 one cycle later; drv_en=0010 on the next cycle.
- req=0011; owner 0 asserts last on 3rd DRIVE beat → drv_en low for 1 TURN cycle → SETUP for requester 1. No cycle has two enables set.
- req[2] held continuously, MAX_HOLD=8 → drv_en[2] high exactly 8 cycles. With req=0101 the next grant is 0001, and the grant returns to 2 after that.
- Requester 3 drops req in SETUP → IDLE, drv_en never asserted, ptr=0. A following req=1000 is granted normally.
- rst asserted mid-DRIVE → gnt, drv_en and busy are 0 in the same cycle. After release, req=1111 grants index 0.
- With SHARED_BUS_ARB_CONTENTION_CHK_EN: drv_seen=0110 while drv_en=0010 → err=1 next cycle and stays 1 until rst.
